// File: rtl/vpu_fetch_pkg.sv
// vpu_fetch_pkg: shared types and constants for the instruction fetch sequencer.
// Build option: FETCH_BKPT_EN adds the PAUSE state used by the breakpoint logic.
package vpu_fetch_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hE;

`ifdef FETCH_BKPT_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_PAUSE = 3'd4
    } fetch_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ISSUE = 3'd3
    } fetch_state_t;
`endif

endpackage

// File: rtl/instr_predecode.sv
// instr_predecode: classifies a fetched word as HALT, JMP or a normal
// instruction and extracts the jump target. Purely combinational.
module instr_predecode
    import vpu_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int AW          = 8
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   is_halt,
    output logic                   is_jmp,
    output logic [AW-1:0]          jmp_target
);

    logic [OPC_W-1:0] opcode_s;
    logic             unused_instr_s;

    assign opcode_s       = instr[INSTR_WIDTH-1 -: OPC_W];
    assign is_halt        = (opcode_s == OP_HALT);
    assign is_jmp         = (opcode_s == OP_JMP);
    assign jmp_target     = instr[AW-1:0];
    // Only the opcode and target fields matter here; the rest is payload.
    assign unused_instr_s = ^instr;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: program counter and fetch sequencer between the
// UART-loaded instruction memory and the vector decode stage. Issues one
// instruction at a time over valid/ready, consumes HALT and JMP itself,
// stops with a sticky error when the pc would run past the last address and
// holds off fetching while the loader owns the memory.
// Build option: define FETCH_BKPT_EN to add a single-address breakpoint
// (ports bkpt_en, bkpt_addr, bkpt_hit and the PAUSE state).
module instr_fetch_ctrl
    import vpu_fetch_pkg::*;
#(
    parameter int  INSTR_WIDTH = 32,
    parameter int  DEPTH       = 256,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          start_addr,
    input  logic                   stop,
    input  logic                   load_busy,
    output logic [AW-1:0]          rd_addr,
    input  logic [INSTR_WIDTH-1:0] rd_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [AW-1:0]          pc,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef FETCH_BKPT_EN
    ,
    input  logic                   bkpt_en,
    input  logic [AW-1:0]          bkpt_addr,
    output logic                   bkpt_hit
`endif
);

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    fetch_state_t           state_r;
    fetch_state_t           state_nxt_s;
    logic [AW-1:0]          rd_addr_r;
    logic [AW-1:0]          rd_addr_nxt_s;
    logic [AW-1:0]          pc_r;
    logic [AW-1:0]          pc_nxt_s;
    logic [INSTR_WIDTH-1:0] instr_out_r;
    logic [INSTR_WIDTH-1:0] instr_out_nxt_s;
    logic                   err_r;
    logic                   err_nxt_s;
    logic                   done_r;
    logic                   done_nxt_s;
    logic                   instr_valid_r;
    logic                   busy_r;
    logic                   is_halt_s;
    logic                   is_jmp_s;
    logic [AW-1:0]          jmp_target_s;
`ifdef FETCH_BKPT_EN
    logic                   bkpt_hit_r;
`endif

    instr_predecode #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .AW          (AW)
    ) u_predecode (
        .instr      (rd_data),
        .is_halt    (is_halt_s),
        .is_jmp     (is_jmp_s),
        .jmp_target (jmp_target_s)
    );

    // Next-state and next-value logic for the fetch sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        rd_addr_nxt_s   = rd_addr_r;
        pc_nxt_s        = pc_r;
        instr_out_nxt_s = instr_out_r;
        err_nxt_s       = err_r;
        done_nxt_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !load_busy && !stop) begin
                    rd_addr_nxt_s = start_addr;
                    pc_nxt_s      = start_addr;
                    err_nxt_s     = 1'b0;
                    state_nxt_s   = ST_ADDR;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (load_busy) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end

            ST_DATA: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (load_busy) begin
                    // Word may be stale: re-read the same address later.
                    state_nxt_s = ST_ADDR;
                end else if (is_halt_s) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (is_jmp_s) begin
                    rd_addr_nxt_s = jmp_target_s;
                    pc_nxt_s      = jmp_target_s;
                    state_nxt_s   = ST_ADDR;
`ifdef FETCH_BKPT_EN
                end else if (bkpt_en && (pc_r == bkpt_addr)) begin
                    instr_out_nxt_s = rd_data;
                    state_nxt_s     = ST_PAUSE;
`endif
                end else begin
                    instr_out_nxt_s = rd_data;
                    state_nxt_s     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (instr_ready) begin
                    // Accepted even when stop arrives in the same cycle.
                    if (pc_r == PC_LAST) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        pc_nxt_s      = pc_r + PC_ONE;
                        rd_addr_nxt_s = pc_r + PC_ONE;
                        state_nxt_s   = stop ? ST_IDLE : ST_ADDR;
                    end
                end else if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end

`ifdef FETCH_BKPT_EN
            ST_PAUSE: begin
                // Resuming goes straight to ISSUE, so the paused word is
                // never fetched again and cannot re-trigger the breakpoint.
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
`endif

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            rd_addr_r     <= {AW{1'b0}};
            pc_r          <= {AW{1'b0}};
            instr_out_r   <= {INSTR_WIDTH{1'b0}};
            err_r         <= 1'b0;
            done_r        <= 1'b0;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef FETCH_BKPT_EN
            bkpt_hit_r    <= 1'b0;
`endif
        end else begin
            state_r       <= state_nxt_s;
            rd_addr_r     <= rd_addr_nxt_s;
            pc_r          <= pc_nxt_s;
            instr_out_r   <= instr_out_nxt_s;
            err_r         <= err_nxt_s;
            done_r        <= done_nxt_s;
            instr_valid_r <= (state_nxt_s == ST_ISSUE);
            busy_r        <= (state_nxt_s != ST_IDLE);
`ifdef FETCH_BKPT_EN
            bkpt_hit_r    <= (state_nxt_s == ST_PAUSE);
`endif
        end
    end

    assign rd_addr     = rd_addr_r;
    assign pc          = pc_r;
    assign instr_out   = instr_out_r;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
`ifdef FETCH_BKPT_EN
    assign bkpt_hit    = bkpt_hit_r;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed timing checks plus randomized programs
// compared against a program-walking reference model.
module tb_instr_fetch_ctrl;

    localparam int IW = 32;
    localparam int DP = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = 8'd0;
    logic          stop = 1'b0;
    logic          load_busy = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data = 32'd0;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;
`ifdef FETCH_BKPT_EN
    logic          bkpt_en = 1'b0;
    logic [AW-1:0] bkpt_addr = 8'd0;
    logic          bkpt_hit;
`endif

    logic [IW-1:0] mem [DP];

    int n_cmp = 0;
    int n_mis = 0;

    // Observed issues and done pulses.
    logic [AW-1:0] obs_pc[$];
    logic [IW-1:0] obs_ins[$];
    int            done_cnt = 0;

    // Expected results from the reference model.
    logic [AW-1:0] exp_pc[$];
    logic [IW-1:0] exp_ins[$];
    int            exp_done;
    int            exp_err;

    instr_fetch_ctrl #(
        .INSTR_WIDTH (IW),
        .DEPTH       (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .stop        (stop),
        .load_busy   (load_busy),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef FETCH_BKPT_EN
        ,
        .bkpt_en     (bkpt_en),
        .bkpt_addr   (bkpt_addr),
        .bkpt_hit    (bkpt_hit)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data follows the address by one edge.
    always @(posedge clk) rd_data <= mem[rd_addr];

    // Record every accepted instruction and every done pulse.
    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready) begin
            obs_pc.push_back(pc);
            obs_ins.push_back(instr_out);
        end
        if (rst && done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int addr);
        start      = 1'b1;
        start_addr = 8'(addr);
        tick();
        start      = 1'b0;
    endtask

    task automatic clear_obs();
        obs_pc.delete();
        obs_ins.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Walk the program as the specification describes it: HALT ends with
    // done, JMP redirects, anything else is issued; running past the last
    // address ends with err.
    task automatic model_run(input int sa);
        int a     = sa;
        int steps = 0;
        logic [IW-1:0] w;
        exp_pc.delete();
        exp_ins.delete();
        exp_done = 0;
        exp_err  = 0;
        while (steps < 4 * DP) begin
            steps++;
            w = mem[a];
            if (w[31:28] == 4'hF) begin
                exp_done = 1;
                break;
            end
            if (w[31:28] == 4'hE) begin
                a = int'(w[7:0]);
                continue;
            end
            exp_pc.push_back(8'(a));
            exp_ins.push_back(w);
            if (a == DP - 1) begin
                exp_err = 1;
                break;
            end
            a++;
        end
    endtask

    // Random program; jumps only go forward so every run terminates.
    task automatic gen_program();
        int r;
        int t;
        logic [3:0] op;
        for (int a = 0; a < DP; a++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                mem[a] = {4'hF, 28'($urandom)};
            end else if (r == 1 && a < DP - 1) begin
                t = a + $urandom_range(1, 8);
                if (t > DP - 1) t = DP - 1;
                mem[a] = {4'hE, 20'($urandom), 8'(t)};
            end else begin
                op = 4'($urandom_range(0, 13));
                mem[a] = {op, 28'($urandom)};
            end
        end
    endtask

    initial begin
        int sa;
        int n;
        for (int a = 0; a < DP; a++) mem[a] = 32'd0;

        // Reset values.
        tick();
        tick();
        check_eq("rst_rd_addr", 64'(rd_addr), 64'd0);
        check_eq("rst_pc", 64'(pc), 64'd0);
        check_eq("rst_instr_out", 64'(instr_out), 64'd0);
        check_eq("rst_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
`ifdef FETCH_BKPT_EN
        check_eq("rst_bkpt_hit", 64'(bkpt_hit), 64'd0);
`endif
        rst = 1'b1;
        tick();

        // Basic program A, B, HALT with cycle-exact timing.
        mem[0] = 32'h1234_5678;
        mem[1] = 32'h2000_0001;
        mem[2] = 32'hF000_0000;
        instr_ready = 1'b1;
        clear_obs();
        start_run(0);
        check_eq("e0_rd_addr", 64'(rd_addr), 64'd0);
        check_eq("e0_busy", 64'(busy), 64'd1);
        check_eq("e0_valid", 64'(instr_valid), 64'd0);
        tick();
        check_eq("e1_valid", 64'(instr_valid), 64'd0);
        tick();
        check_eq("e2_issue_a", {instr_valid, pc, instr_out}, {1'b1, 8'd0, 32'h1234_5678});
        tick();
        check_eq("e3_valid", 64'(instr_valid), 64'd0);
        check_eq("e3_rd_addr", 64'(rd_addr), 64'd1);
        tick();
        tick();
        check_eq("e5_issue_b", {instr_valid, pc, instr_out}, {1'b1, 8'd1, 32'h2000_0001});
        tick();
        tick();
        tick();
        check_eq("halt_done", 64'(done), 64'd1);
        check_eq("halt_busy", 64'(busy), 64'd0);
        tick();
        check_eq("done_pulse", 64'(done), 64'd0);
        check_eq("halt_issues", 64'(obs_pc.size()), 64'd2);

        // Stall, single-cycle accept, JMP, then stop in ISSUE.
        mem[2]  = 32'h5555_0002;
        mem[3]  = 32'hE000_000A;
        mem[10] = 32'h6666_000A;
        mem[11] = 32'hF000_0000;
        instr_ready = 1'b0;
        clear_obs();
        start_run(2);
        tick();
        tick();
        check_eq("stall_first", {instr_valid, pc, instr_out}, {1'b1, 8'd2, 32'h5555_0002});
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("stall_hold", {instr_valid, pc, instr_out}, {1'b1, 8'd2, 32'h5555_0002});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("accept_pc", 64'(pc), 64'd3);
        check_eq("accept_valid", 64'(instr_valid), 64'd0);
        tick();
        tick();
        check_eq("jmp_rd_addr", {rd_addr, pc, instr_valid}, {8'd10, 8'd10, 1'b0});
        tick();
        tick();
        check_eq("jmp_issue", {instr_valid, pc, instr_out}, {1'b1, 8'd10, 32'h6666_000A});
        check_eq("jmp_not_issued", 64'(obs_ins.size()), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_idle", {instr_valid, busy, done}, {1'b0, 1'b0, 1'b0});
        tick();
        check_eq("stop_no_done", 64'(done_cnt), 64'd0);

        // load_busy while in DATA: re-read the same address, new contents issued.
        mem[20] = 32'h3333_0000;
        clear_obs();
        start_run(20);
        tick();
        load_busy = 1'b1;
        mem[20] = 32'h4444_0001;
        tick();
        check_eq("lb_back_addr", {instr_valid, rd_addr}, {1'b0, 8'd20});
        tick();
        tick();
        check_eq("lb_hold", {instr_valid, busy}, {1'b0, 1'b1});
        load_busy = 1'b0;
        tick();
        tick();
        check_eq("lb_issue_new", {instr_valid, pc, instr_out}, {1'b1, 8'd20, 32'h4444_0001});
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Overflow at the last address, then err cleared by a new start.
        mem[255] = 32'h1111_1111;
        mem[5]   = 32'hF000_0000;
        instr_ready = 1'b1;
        start_run(255);
        tick();
        tick();
        tick();
        check_eq("ovf_state", {err, busy, instr_valid, pc}, {1'b1, 1'b0, 1'b0, 8'd255});
        tick();
        check_eq("err_sticky", 64'(err), 64'd1);
        start_run(5);
        check_eq("err_cleared", 64'(err), 64'd0);
        wait_idle(50);

        // start with stop in IDLE is ignored; start with load_busy too.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        check_eq("start_stop_idle", 64'(busy), 64'd0);
        load_busy = 1'b1;
        start_run(0);
        load_busy = 1'b0;
        tick();
        check_eq("start_lb_idle", 64'(busy), 64'd0);

`ifdef FETCH_BKPT_EN
        // Breakpoint at address 2, resumed with start.
        mem[0] = 32'h0100_0000;
        mem[1] = 32'h0200_0000;
        mem[2] = 32'h0300_0002;
        mem[3] = 32'hF000_0000;
        bkpt_en   = 1'b1;
        bkpt_addr = 8'd2;
        clear_obs();
        start_run(0);
        n = 0;
        while (!bkpt_hit && n < 50) begin
            tick();
            n++;
        end
        check_eq("bkpt_hit", {bkpt_hit, instr_valid, busy}, {1'b1, 1'b0, 1'b1});
        check_eq("bkpt_issues", 64'(obs_pc.size()), 64'd2);
        start_run(0);
        check_eq("bkpt_resume", {bkpt_hit, instr_valid, pc, instr_out}, {1'b0, 1'b1, 8'd2, 32'h0300_0002});
        wait_idle(50);
        tick();
        check_eq("bkpt_done", 64'(done_cnt), 64'd1);
        bkpt_en = 1'b0;
`endif

        // Randomized programs with random ready and load_busy.
        for (int r = 0; r < 12; r++) begin
            gen_program();
            sa = (r % 3 == 0) ? $urandom_range(240, 255) : $urandom_range(0, 200);
            model_run(sa);
            clear_obs();
            load_busy = 1'b0;
            start_run(sa);
            check_eq("rnd_started", 64'(busy), 64'd1);
            n = 0;
            while (busy && n < 5000) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                load_busy   = ($urandom_range(0, 9) == 0);
                tick();
                n++;
            end
            load_busy   = 1'b0;
            instr_ready = 1'b0;
            check_eq("rnd_timeout", 64'(busy), 64'd0);
            tick();
            check_eq("rnd_issue_cnt", 64'(obs_pc.size()), 64'(exp_pc.size()));
            for (int i = 0; i < exp_pc.size() && i < obs_pc.size(); i++) begin
                check_eq("rnd_pc", 64'(obs_pc[i]), 64'(exp_pc[i]));
                check_eq("rnd_instr", 64'(obs_ins[i]), 64'(exp_ins[i]));
            end
            check_eq("rnd_done", 64'(done_cnt), 64'(exp_done));
            check_eq("rnd_err", 64'(err), 64'(exp_err));
        end

        // Asynchronous reset mid-run returns everything to reset values.
        mem[0] = 32'h0700_0000;
        instr_ready = 1'b0;
        start_run(0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst", {busy, instr_valid, pc, rd_addr, instr_out}, 64'd0);
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
